div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter_if.sv | 19 +
 rtl/div_iter.sv | 95 +++++++++
 tb/tb_div_iter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
// Request/result bundle for the iterative divider: operands and controls in, result and status out.
interface div_iter_if;
  localparam int unsigned IN_W  = 33;
  localparam int unsigned OUT_W = 32;

  logic             pause;
  logic             div_en;
  logic             rem_sel;
  logic [IN_W-1:0]  din1;
  logic [IN_W-1:0]  din2;
  logic [OUT_W-1:0] dout;
  logic             vldout;
  logic             busy;

  modport master (output pause, div_en, rem_sel, din1, din2,
                  input  dout, vldout, busy);
  modport slave  (input  pause, div_en, rem_sel, din1, din2,
                  output dout, vldout, busy);
endinterface

// File: rtl/div_iter.sv
// Sign-magnitude restoring radix-2 divider: 33-bit two's-complement operands, 32-bit quotient or
// remainder after 32 iterations; a zero divisor short-circuits straight to the result.
module div_iter (
  input logic       clk,
  input logic       reset,
  div_iter_if.slave bus
);
  localparam int unsigned IN_W  = 33;
  localparam int unsigned OUT_W = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IN_W-1:0]  r_rem;
  logic [OUT_W-1:0] r_dvd;
  logic [OUT_W-1:0] r_dvs;
  logic             r_s1;
  logic             r_s2;
  logic             r_sel;
  logic [OUT_W-1:0] r_dout;

  logic [OUT_W-1:0] w_mag1;
  logic [OUT_W-1:0] w_mag2;
  logic [IN_W:0]    w_shift;
  logic [IN_W:0]    w_diff;
  logic             w_qbit;
  logic [IN_W-1:0]  w_rem_nx;
  logic [OUT_W-1:0] w_quo_nx;
  logic [OUT_W-1:0] w_quo_fin;
  logic [OUT_W-1:0] w_rem_fin;

  assign w_mag1 = bus.din1[IN_W-1] ? OUT_W'(-bus.din1) : bus.din1[OUT_W-1:0];
  assign w_mag2 = bus.din2[IN_W-1] ? OUT_W'(-bus.din2) : bus.din2[OUT_W-1:0];

  // Partial remainder stays below 2^33, so bit 33 of the difference is the borrow.
  assign w_shift   = {r_rem, r_dvd[OUT_W-1]};
  assign w_diff    = w_shift - {2'b00, r_dvs};
  assign w_qbit    = ~w_diff[IN_W];
  assign w_rem_nx  = w_qbit ? w_diff[IN_W-1:0] : w_shift[IN_W-1:0];
  assign w_quo_nx  = {r_dvd[OUT_W-2:0], w_qbit};
  assign w_quo_fin = (r_s1 ^ r_s2) ? -w_quo_nx : w_quo_nx;
  assign w_rem_fin = r_s1 ? -w_rem_nx[OUT_W-1:0] : w_rem_nx[OUT_W-1:0];

  assign bus.dout   = r_dout;
  assign bus.vldout = (r_state == ST_DONE) & ~bus.pause;
  assign bus.busy   = (r_state != ST_IDLE);

  // Dividend register shifts out MSBs and fills with quotient bits from the right.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_sel   <= 1'b0;
      r_dout  <= '0;
    end else if (!bus.pause) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.div_en) begin
            r_sel <= bus.rem_sel;
            if (bus.din2 == '0) begin
              r_state <= ST_DONE;
              r_dout  <= bus.rem_sel ? bus.din1[OUT_W-1:0] : '1;
            end else begin
              r_state <= ST_RUN;
              r_dvd   <= w_mag1;
              r_dvs   <= w_mag2;
              r_s1    <= bus.din1[IN_W-1];
              r_s2    <= bus.din2[IN_W-1];
              r_cnt   <= '0;
              r_rem   <= '0;
            end
          end
        end
        ST_RUN: begin
          r_rem <= w_rem_nx;
          r_dvd <= w_quo_nx;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(31)) begin
            r_state <= ST_DONE;
            r_dout  <= r_sel ? w_rem_fin : w_quo_fin;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed vector table, random ops against an arithmetic model,
// and cycle-exact pause / reset / request-rejection sequences.
module tb_div_iter;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  div_iter_if bus ();

  div_iter u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [32:0] a;
    logic [32:0] b;
    logic        sel;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: divide magnitudes as plain integers, then apply sign rules.
  function automatic logic [31:0] ref_div(input logic [32:0] a, input logic [32:0] b, input logic sel);
    longint sa, sb, m1, m2, q, r;
    if (b == 33'd0) return sel ? a[31:0] : 32'hFFFF_FFFF;
    sa = a[32] ? longint'(a) - 64'sh2_0000_0000 : longint'(a);
    sb = b[32] ? longint'(b) - 64'sh2_0000_0000 : longint'(b);
    m1 = (sa < 0) ? -sa : sa;
    m2 = (sb < 0) ? -sb : sb;
    q  = m1 / m2;
    r  = m1 % m2;
    if (a[32] ^ b[32]) q = -q;
    if (a[32]) r = -r;
    return sel ? r[31:0] : q[31:0];
  endfunction

  // Issue an op in the current cycle, find the vldout cycle, then probe the DONE cycle.
  task automatic run_op(input logic [32:0] a, input logic [32:0] b, input logic sel,
                        input logic [31:0] exp, input int lat, input string name);
    int seen;
    seen = -1;
    bus.din1 = a; bus.din2 = b; bus.rem_sel = sel; bus.div_en = 1'b1;
    for (int c = 1; c <= lat + 3 && seen < 0; c++) begin
      step();
      bus.div_en = 1'b0;
      if (bus.vldout) seen = c;
    end
    check({name, "_lat"}, 64'(seen), 64'(lat));
    check({name, "_dout"}, 64'(bus.dout), 64'(exp));
    // A request during DONE must be dropped.
    bus.div_en = 1'b1; bus.din2 = 33'd0;
    step();
    bus.div_en = 1'b0;
    check({name, "_done_ign"}, 64'(bus.busy), 64'd0);
    check({name, "_hold"}, 64'(bus.dout), 64'(exp));
  endtask

  initial begin
    logic [31:0] x, y;
    logic [32:0] a, b;
    logic        sel;
    n_checks = 0; n_fail = 0;
    reset = 1'b1;
    bus.pause = 1'b0; bus.div_en = 1'b0; bus.rem_sel = 1'b0;
    bus.din1 = '0; bus.din2 = '0;
    step(); step();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_vld", 64'(bus.vldout), 64'd0);
    check("rst_dout", 64'(bus.dout), 64'd0);
    reset = 1'b0;
    step();

    vecs[0] = '{33'h0_0000_0064, 33'h0_0000_0007, 1'b0, 32'h0000_000E, 33, "udiv_q"};
    vecs[1] = '{33'h0_0000_0064, 33'h0_0000_0007, 1'b1, 32'h0000_0002, 33, "udiv_r"};
    vecs[2] = '{33'h1_FFFF_FFF9, 33'h0_0000_0002, 1'b0, 32'hFFFF_FFFD, 33, "sdiv_q"};
    vecs[3] = '{33'h1_FFFF_FFF9, 33'h0_0000_0002, 1'b1, 32'hFFFF_FFFF, 33, "sdiv_r"};
    vecs[4] = '{33'h0_0000_002A, 33'h0_0000_0000, 1'b0, 32'hFFFF_FFFF, 1,  "dz_q"};
    vecs[5] = '{33'h0_0000_002A, 33'h0_0000_0000, 1'b1, 32'h0000_002A, 1,  "dz_r"};
    vecs[6] = '{33'h1_FFFF_FFD6, 33'h0_0000_0000, 1'b1, 32'hFFFF_FFD6, 1,  "dz_neg_r"};
    vecs[7] = '{33'h1_8000_0000, 33'h1_FFFF_FFFF, 1'b0, 32'h8000_0000, 33, "ovf_q"};
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp, vecs[i].lat, vecs[i].name);
    run_op(33'h1_8000_0000, 33'h1_FFFF_FFFF, 1'b1, 32'h0, 33, "ovf_r");

    // Pause+div_en together in IDLE is not a request.
    bus.pause = 1'b1; bus.div_en = 1'b1; bus.din1 = 33'd9; bus.din2 = 33'd3;
    step();
    check("pause_req_busy", 64'(bus.busy), 64'd0);
    bus.pause = 1'b0; bus.div_en = 1'b0;
    step();
    check("pause_req_busy2", 64'(bus.busy), 64'd0);

    // Pause in cycles 10..14 and a stray request at cycle 20.
    bus.din1 = 33'h0_0000_0064; bus.din2 = 33'h0_0000_0007; bus.rem_sel = 1'b0; bus.div_en = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      bus.pause  = (c >= 10 && c <= 14);
      bus.div_en = (c == 20);
      #1;
      check($sformatf("pause_vld_c%0d", c), 64'(bus.vldout), 64'(c == 38));
      if (c == 38) check("pause_dout", 64'(bus.dout), 64'h0000_000E);
    end
    bus.pause = 1'b0; bus.div_en = 1'b0;

    // Reset in cycle 12 aborts; new op from cycle 13 lands at 46.
    bus.div_en = 1'b1;
    for (int c = 1; c <= 48; c++) begin
      step();
      reset      = (c == 12);
      bus.div_en = (c == 13);
      #1;
      if (c == 13) begin
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_dout", 64'(bus.dout), 64'd0);
      end
      if (c >= 12) check($sformatf("rst_vld_c%0d", c), 64'(bus.vldout), 64'(c == 46));
      if (c == 46) check("rst_new_dout", 64'(bus.dout), 64'h0000_000E);
    end
    reset = 1'b0; bus.div_en = 1'b0;
    step();

    // Random ops, mixing unsigned and sign-extended encodings.
    for (int k = 0; k < 30; k++) begin
      x = $urandom();
      y = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(1, 100));
      if ($urandom_range(0, 7) == 0) y = 32'd0;
      if ($urandom_range(0, 1) == 1) begin
        a = {x[31], x};
        if ($urandom_range(0, 1) == 1) y = -y;
        b = (y == 32'd0) ? 33'd0 : {y[31], y};
      end else begin
        a = {1'b0, x};
        b = {1'b0, y};
      end
      sel = 1'($urandom_range(0, 1));
      run_op(a, b, sel, ref_div(a, b, sel), (b == 33'd0) ? 1 : 33, $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
